// File: rtl/null_src_sink_pkg.sv
// Shared definitions for the null source/sink/loopback core:
// register map, counter width and source FSM states.
package null_src_sink_pkg;

  localparam int unsigned CNT_W   = 64;
  localparam int unsigned NUM_CNT = 6;

  localparam logic [19:0] REG_CTRL_STATUS        = 20'h00;
  localparam logic [19:0] REG_SRC_LINES_PER_PKT  = 20'h04;
  localparam logic [19:0] REG_SRC_BYTES_PER_PKT  = 20'h08;
  localparam logic [19:0] REG_SRC_LINE_CNT_LO    = 20'h10;
  localparam logic [19:0] REG_SRC_LINE_CNT_HI    = 20'h14;
  localparam logic [19:0] REG_SRC_PKT_CNT_LO     = 20'h18;
  localparam logic [19:0] REG_SRC_PKT_CNT_HI     = 20'h1C;
  localparam logic [19:0] REG_SNK_LINE_CNT_LO    = 20'h20;
  localparam logic [19:0] REG_SNK_LINE_CNT_HI    = 20'h24;
  localparam logic [19:0] REG_SNK_PKT_CNT_LO     = 20'h28;
  localparam logic [19:0] REG_SNK_PKT_CNT_HI     = 20'h2C;
  localparam logic [19:0] REG_LOOP_LINE_CNT_LO   = 20'h30;
  localparam logic [19:0] REG_LOOP_LINE_CNT_HI   = 20'h34;
  localparam logic [19:0] REG_LOOP_PKT_CNT_LO    = 20'h38;
  localparam logic [19:0] REG_LOOP_PKT_CNT_HI    = 20'h3C;

  typedef enum logic {
    SRC_IDLE,
    SRC_RUN
  } src_state_t;

endpackage

// File: rtl/null_src_sink_counter.sv
// Line and packet counters for one stream port; clear has priority
// over increment and both counters wrap silently.
module null_src_sink_counter
  import null_src_sink_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic             ready,
  input  logic             last,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] pkt_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (clear) begin
      line_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (valid && ready) begin
      line_cnt <= line_cnt + 1'b1;
      if (last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/null_src_sink_core.sv
// Payload core of the null source/sink/loopback block: counting-pattern
// source on m0, discarding sink on s0, loopback s1->m1, register bus.
module null_src_sink_core
  import null_src_sink_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int ITEM_W = 32,
  parameter int NIPC   = 2
) (
  input  logic              rfnoc_chdr_clk,
  input  logic              rfnoc_chdr_rst_n,
  input  logic [CHDR_W-1:0] s0_tdata,
  input  logic              s0_tlast,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [CHDR_W-1:0] s1_tdata,
  input  logic              s1_tlast,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  output logic [CHDR_W-1:0] m0_tdata,
  output logic              m0_tlast,
  output logic              m0_tvalid,
  input  logic              m0_tready,
  output logic [15:0]       m0_tlength,
  output logic [CHDR_W-1:0] m1_tdata,
  output logic              m1_tlast,
  output logic              m1_tvalid,
  input  logic              m1_tready,
  input  logic              ctrlport_req_wr,
  input  logic              ctrlport_req_rd,
  input  logic [19:0]       ctrlport_req_addr,
  input  logic [31:0]       ctrlport_req_data,
  output logic              ctrlport_resp_ack,
  output logic [31:0]       ctrlport_resp_data
);

  logic             clk, rst_n;
  logic             src_en, clear;
  logic [31:0]      lines_per_pkt, bytes_per_pkt, rd_mux;
  logic [31:0]      shadow [NUM_CNT];
  logic [CNT_W-1:0] cnt_val [NUM_CNT];

  assign clk   = rfnoc_chdr_clk;
  assign rst_n = rfnoc_chdr_rst_n;

  // Loopback and sink
  assign m1_tdata   = s1_tdata;
  assign m1_tlast   = s1_tlast;
  assign m1_tvalid  = s1_tvalid;
  assign s1_tready  = m1_tready;
  assign s0_tready  = 1'b1;
  assign m0_tlength = bytes_per_pkt[15:0];

  assign clear = ctrlport_req_wr && (ctrlport_req_addr == REG_CTRL_STATUS) && ctrlport_req_data[0];

  null_src_sink_counter u_src_cnt (.clk(clk), .rst_n(rst_n), .clear(clear),
    .valid(m0_tvalid), .ready(m0_tready), .last(m0_tlast),
    .line_cnt(cnt_val[0]), .pkt_cnt(cnt_val[1]));
  null_src_sink_counter u_snk_cnt (.clk(clk), .rst_n(rst_n), .clear(clear),
    .valid(s0_tvalid), .ready(1'b1), .last(s0_tlast),
    .line_cnt(cnt_val[2]), .pkt_cnt(cnt_val[3]));
  null_src_sink_counter u_loop_cnt (.clk(clk), .rst_n(rst_n), .clear(clear),
    .valid(s1_tvalid), .ready(m1_tready), .last(s1_tlast),
    .line_cnt(cnt_val[4]), .pkt_cnt(cnt_val[5]));

  always_comb begin
    rd_mux = '0;
    case (ctrlport_req_addr)
      REG_CTRL_STATUS:       rd_mux = {8'(NIPC), 8'(ITEM_W), 14'd0, src_en, 1'b0};
      REG_SRC_LINES_PER_PKT: rd_mux = lines_per_pkt;
      REG_SRC_BYTES_PER_PKT: rd_mux = bytes_per_pkt;
      default: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (ctrlport_req_addr == REG_SRC_LINE_CNT_LO + 20'(i * 8))
            rd_mux = cnt_val[i][31:0];
          if (ctrlport_req_addr == REG_SRC_LINE_CNT_HI + 20'(i * 8))
            rd_mux = shadow[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_en             <= 1'b0;
      lines_per_pkt      <= '0;
      bytes_per_pkt      <= '0;
      ctrlport_resp_ack  <= 1'b0;
      ctrlport_resp_data <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else begin
      ctrlport_resp_ack  <= ctrlport_req_rd || ctrlport_req_wr;
      ctrlport_resp_data <= ctrlport_req_rd ? rd_mux : '0;
      if (ctrlport_req_wr) begin
        case (ctrlport_req_addr)
          REG_CTRL_STATUS:       src_en        <= ctrlport_req_data[1];
          REG_SRC_LINES_PER_PKT: lines_per_pkt <= ctrlport_req_data;
          REG_SRC_BYTES_PER_PKT: bytes_per_pkt <= ctrlport_req_data;
          default: ;
        endcase
      end
      if (ctrlport_req_rd) begin
        for (int unsigned i = 0; i < NUM_CNT; i++)
          if (ctrlport_req_addr == REG_SRC_LINE_CNT_LO + 20'(i * 8))
            shadow[i] <= cnt_val[i][63:32];
      end
    end
  end

  // Source FSM; m0 beat outputs are computed one cycle ahead and registered
  src_state_t        state, state_nxt;
  logic [31:0]       beat, beat_nxt, plen, plen_nxt;
  logic              tvalid_nxt, tlast_nxt, hs;
  logic [CHDR_W-1:0] tdata_nxt;
  logic [CNT_W-1:0]  cur_line, next_line;

  function automatic logic [CHDR_W-1:0] line_pattern(input logic [CNT_W-1:0] l);
    logic [CHDR_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NIPC; i++)
      p[i*ITEM_W +: ITEM_W] = {~l[ITEM_W/2-1:0], l[ITEM_W/2-1:0]};
    return p;
  endfunction

  assign hs        = m0_tvalid && m0_tready;
  assign cur_line  = clear ? '0 : cnt_val[0];
  assign next_line = clear ? '0 : cnt_val[0] + 1'b1;

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    plen_nxt   = plen;
    tvalid_nxt = m0_tvalid;
    tlast_nxt  = m0_tlast;
    tdata_nxt  = m0_tdata;
    case (state)
      SRC_IDLE: begin
        beat_nxt = '0;
        if (src_en) begin
          state_nxt  = SRC_RUN;
          tvalid_nxt = 1'b1;
          plen_nxt   = lines_per_pkt;
          tdata_nxt  = line_pattern(cur_line);
          tlast_nxt  = (lines_per_pkt == '0);
        end
      end
      SRC_RUN: begin
        if (hs && m0_tlast) begin
          beat_nxt = '0;
          if (src_en) begin
            plen_nxt  = lines_per_pkt;
            tdata_nxt = line_pattern(next_line);
            tlast_nxt = (lines_per_pkt == '0);
          end else begin
            state_nxt  = SRC_IDLE;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
          end
        end else if (hs) begin
          beat_nxt  = beat + 1'b1;
          tdata_nxt = line_pattern(next_line);
          tlast_nxt = (beat + 1'b1 == plen);
        end
      end
      default: state_nxt = SRC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SRC_IDLE;
      beat      <= '0;
      plen      <= '0;
      m0_tvalid <= 1'b0;
      m0_tlast  <= 1'b0;
      m0_tdata  <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      plen      <= plen_nxt;
      m0_tvalid <= tvalid_nxt;
      m0_tlast  <= tlast_nxt;
      m0_tdata  <= tdata_nxt;
    end
  end

endmodule

// File: tb/tb_null_src_sink_core.sv
// Directed/randomized bench for null_src_sink_core with a behavioural
// model of the source pattern, loopback and counters.
module tb_null_src_sink_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s0_tdata = '0, s1_tdata = '0, m0_tdata, m1_tdata;
  logic        s0_tlast = 1'b0, s0_tvalid = 1'b0, s0_tready;
  logic        s1_tlast = 1'b0, s1_tvalid = 1'b0, s1_tready;
  logic        m0_tlast, m0_tvalid, m0_tready = 1'b0;
  logic        m1_tlast, m1_tvalid, m1_tready = 1'b0;
  logic [15:0] m0_tlength;
  logic        req_wr = 1'b0, req_rd = 1'b0, resp_ack;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0, resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  null_src_sink_core #(.CHDR_W(64), .ITEM_W(32), .NIPC(2)) dut (
    .rfnoc_chdr_clk(clk), .rfnoc_chdr_rst_n(rst_n),
    .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
    .m0_tlength(m0_tlength),
    .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
    .ctrlport_req_wr(req_wr), .ctrlport_req_rd(req_rd), .ctrlport_req_addr(req_addr),
    .ctrlport_req_data(req_data), .ctrlport_resp_ack(resp_ack), .ctrlport_resp_data(resp_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [19:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_wr = 1'b1; req_addr = addr; req_data = data;
    @(negedge clk);
    req_wr = 1'b0;
    check("wr_ack", resp_ack, 1);
  endtask

  task automatic bus_read(input logic [19:0] addr, output logic [31:0] data);
    @(negedge clk);
    req_rd = 1'b1; req_addr = addr;
    @(negedge clk);
    req_rd = 1'b0;
    check("rd_ack", resp_ack, 1);
    data = resp_data;
  endtask

  task automatic read_cnt(input logic [19:0] addr, output logic [63:0] val);
    logic [31:0] lo, hi;
    bus_read(addr, lo);
    bus_read(addr + 20'h4, hi);
    val = {hi, lo};
  endtask

  // Expected counter values, indexed like the register map: src line/pkt, snk, loop
  logic [63:0] exp_cnt [6];

  task automatic check_counters(input string tag);
    logic [63:0] v;
    for (int k = 0; k < 6; k++) begin
      read_cnt(20'h10 + 20'(k * 8), v);
      check($sformatf("%s_cnt%0d", tag, k), v, exp_cnt[k]);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] data, exp_data, held_data;
    logic [63:0] exp_line;
    int bad, beat, pkts, done, stop_req, stalled;
    logic held_last;

    for (int k = 0; k < 6; k++) exp_cnt[k] = '0;

    // Reset state
    #23;
    check("rst_m0_tvalid", m0_tvalid, 0);
    check("rst_resp_ack", resp_ack, 0);
    check("rst_resp_data", resp_data, 0);
    rst_n = 1'b1;
    bus_read(20'h00, rd);  check("ctrl_reset", rd, 32'h0220_0000);
    bus_read(20'h04, rd);  check("lines_reset", rd, 0);
    bus_read(20'h08, rd);  check("bytes_reset", rd, 0);
    bus_read(20'h0C, rd);  check("unmapped_0c", rd, 0);
    bus_write(20'h40, 32'hFFFF_FFFF);
    bus_read(20'h40, rd);  check("unmapped_40", rd, 0);
    check_counters("reset");

    // Loopback: 50 packets of 101 lines, random gaps and backpressure
    bad = 0;
    for (int p = 0; p < 50; p++) begin
      for (int l = 0; l < 101; l++) begin
        logic acc;
        data = {$urandom, $urandom};
        acc = 1'b0;
        while (!acc) begin
          @(negedge clk);
          s1_tdata  = data;
          s1_tlast  = (l == 100);
          s1_tvalid = ($urandom_range(0, 3) != 0);
          m1_tready = ($urandom_range(0, 3) != 0);
          #1;
          if (m1_tdata !== data || m1_tlast !== (l == 100) || m1_tvalid !== s1_tvalid ||
              s1_tready !== m1_tready || s0_tready !== 1'b1) bad++;
          acc = s1_tvalid && m1_tready;
        end
      end
    end
    @(negedge clk);
    s1_tvalid = 1'b0;
    check("loop_passthru_bad", bad, 0);
    exp_cnt[4] = 5050; exp_cnt[5] = 50;
    check_counters("loop");

    // Sink: 50 packets of 101 lines with random gaps
    for (int p = 0; p < 50; p++) begin
      for (int l = 0; l < 101; l++) begin
        logic acc;
        acc = 1'b0;
        while (!acc) begin
          @(negedge clk);
          s0_tdata  = {$urandom, $urandom};
          s0_tlast  = (l == 100);
          s0_tvalid = ($urandom_range(0, 2) != 0);
          acc = s0_tvalid;
        end
      end
    end
    @(negedge clk);
    s0_tvalid = 1'b0;
    exp_cnt[2] = 5050; exp_cnt[3] = 50;
    check_counters("sink");

    // Source: 101-line packets, random backpressure, disable mid-stream
    bus_write(20'h04, 100);
    bus_write(20'h08, 816);
    bus_write(20'h00, 2);
    bus_read(20'h00, rd);  check("ctrl_src_en", rd, 32'h0220_0002);
    exp_line = 0; beat = 0; pkts = 0; bad = 0; done = 0; stop_req = 0; stalled = 0;
    held_data = '0; held_last = 1'b0;
    fork
      begin
        repeat (700) @(negedge clk);
        bus_write(20'h00, 0);
        stop_req = 1;
      end
      begin
        for (int cyc = 0; cyc < 5000 && done == 0; cyc++) begin
          @(negedge clk);
          if (stalled != 0 &&
              (m0_tvalid !== 1'b1 || m0_tdata !== held_data || m0_tlast !== held_last)) bad++;
          if (m0_tvalid) begin
            exp_data = {2{~exp_line[15:0], exp_line[15:0]}};
            if (m0_tdata !== exp_data || m0_tlast !== (beat == 100) || m0_tlength !== 16'd816) bad++;
            m0_tready = ($urandom_range(0, 2) != 0);
            if (m0_tready) begin
              stalled = 0;
              exp_line++;
              if (beat == 100) begin beat = 0; pkts++; end
              else beat++;
            end else begin
              stalled = 1; held_data = m0_tdata; held_last = m0_tlast;
            end
          end else begin
            stalled = 0;
            m0_tready = $urandom_range(0, 1);
            if (stop_req != 0) done = 1;
          end
        end
      end
    join
    check("src_stopped", done, 1);
    check("src_data_bad", bad, 0);
    check("src_whole_pkts", beat, 0);
    check("src_min_pkts", (pkts >= 3), 1);
    check("src_line_vs_pkt", exp_line, 64'(101 * pkts));
    bad = 0;
    m0_tready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (m0_tvalid !== 1'b0) bad++;
    end
    check("src_idle_after_stop", bad, 0);
    exp_cnt[0] = exp_line; exp_cnt[1] = 64'(pkts);
    check_counters("src");

    // Clear all counters
    bus_write(20'h00, 1);
    for (int k = 0; k < 6; k++) exp_cnt[k] = '0;
    check_counters("clear");

    // Asynchronous reset in the middle of a packet
    bus_write(20'h00, 2);
    repeat (30) @(negedge clk);
    check("mid_pkt_tvalid", m0_tvalid, 1);
    check("mid_pkt_tlast", m0_tlast, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", m0_tvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m0_tready = 1'b0;
    bus_read(20'h00, rd);  check("ctrl_after_rst", rd, 32'h0220_0000);
    bus_read(20'h04, rd);  check("lines_after_rst", rd, 0);
    check_counters("rst");
    check("post_rst_tvalid", m0_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
